// File: rtl/ls_pkg.sv
// ls_pkg: shared widths and types for the RV64 load/store datapath.
// Imported by ls_regfile and load_store_datapath.
package ls_pkg;

    localparam int XLEN              = 64;
    localparam int NREGS             = 32;
    localparam int REG_AW            = 5;
    localparam int MEM_DEPTH_DEFAULT = 64;
    localparam int MEM_AW_DEFAULT    = $clog2(MEM_DEPTH_DEFAULT);

    typedef logic [XLEN-1:0]           word_t;
    typedef logic [REG_AW-1:0]         reg_idx_t;
    typedef logic [MEM_AW_DEFAULT-1:0] mem_addr_t;

    // Zero-extend the 5-bit instruction offset to a full data word.
    function automatic word_t zext_offset(input logic [4:0] off);
        return {{(XLEN-5){1'b0}}, off};
    endfunction

endpackage

// File: rtl/ls_regfile.sv
// ls_regfile: 32 x XLEN integer register file.
// Two combinational read ports, one synchronous write port, x0 reads as zero
// and ignores writes. Asynchronous active-high reset clears every register.
module ls_regfile
    import ls_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t ra_idx,
    input  reg_idx_t rb_idx,
    input  reg_idx_t rw_idx,
    input  logic     we,
    input  word_t    wd,
    output word_t    ra_data,
    output word_t    rb_data
);

    word_t regs [NREGS];

    // Register storage: async clear, write on rising edge unless the target is x0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rw_idx != '0)) begin
            regs[rw_idx] <= wd;
        end
    end

    // Read ports are purely combinational; x0 is forced to zero at the mux.
    assign ra_data = (ra_idx == '0) ? '0 : regs[ra_idx];
    assign rb_data = (rb_idx == '0) ? '0 : regs[rb_idx];

endmodule

// File: rtl/load_store_datapath.sv
// load_store_datapath: single-cycle RV64 ld/sd datapath.
//   ld rd,C(rs1): RF[Rw] <= MEM[(RF[Rb] + C) mod MEM_DEPTH]
//   sd rs2,C(rs1): MEM[(RF[Rb] + C) mod MEM_DEPTH] <= RF[Ra]
// There is no handshake: the control strobes WE_RF / WE_MEM are sampled on
// every rising CLK edge, one operation per cycle, never stalling.
// Optional build macro LOAD_STORE_DEBUG_EN: when defined, DEBUG_Dout and
// DEBUG_Ra_out expose the memory read word and RF[Ra]; otherwise both are 0.
module load_store_datapath
    import ls_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
)
(
    input  logic            CLK,
    input  logic            RST,
    input  logic [4:0]      Ra,
    input  logic [4:0]      Rb,
    input  logic [4:0]      Rw,
    input  logic [4:0]      C,
    input  logic            WE_RF,
    input  logic            WE_MEM,
    output logic [XLEN-1:0] DEBUG_Dout,
    output logic [XLEN-1:0] DEBUG_Ra_out
);

    localparam int AW = $clog2(MEM_DEPTH);

    word_t          ra_data;
    word_t          rb_data;
    word_t          addr;
    word_t          mem_rdata;
    logic [AW-1:0]  mem_idx;
    logic           unused_addr_hi;
    word_t          mem [MEM_DEPTH];

    ls_regfile u_regfile (
        .clk     (CLK),
        .rst     (RST),
        .ra_idx  (Ra),
        .rb_idx  (Rb),
        .rw_idx  (Rw),
        .we      (WE_RF),
        .wd      (mem_rdata),
        .ra_data (ra_data),
        .rb_data (rb_data)
    );

    // Full-width effective address; only the low AW bits select a word, so
    // the memory wraps modulo MEM_DEPTH.
    assign addr           = rb_data + zext_offset(C);
    assign mem_idx        = addr[AW-1:0];
    assign unused_addr_hi = ^addr[XLEN-1:AW];

    // Combinational memory read: the load path and debug port see it with zero latency.
    assign mem_rdata = mem[mem_idx];

    // Data memory: async reset loads each word with its own index; stores
    // write the pre-edge RF[Ra], so a same-edge load still sees the old word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= word_t'(i);
            end
        end else if (WE_MEM) begin
            mem[mem_idx] <= ra_data;
        end
    end

`ifdef LOAD_STORE_DEBUG_EN
    assign DEBUG_Dout   = mem_rdata;
    assign DEBUG_Ra_out = ra_data;
`else
    assign DEBUG_Dout   = '0;
    assign DEBUG_Ra_out = '0;
`endif

endmodule

// File: tb/tb_load_store_datapath.sv
// tb_load_store_datapath: directed plus randomized bench for load_store_datapath.
// The reference model is an array-level view of the architectural state
// (32 registers, MEM_DEPTH words) updated by the ld/sd rules each cycle.
`ifndef LOAD_STORE_DEBUG_EN
`define LOAD_STORE_DEBUG_EN
`endif
module tb_load_store_datapath;
    import ls_pkg::*;

    localparam int DEPTH = 64;

    logic        CLK;
    logic        RST;
    logic [4:0]  Ra, Rb, Rw, C;
    logic        WE_RF, WE_MEM;
    logic [63:0] DEBUG_Dout, DEBUG_Ra_out;

    // Reference architectural state.
    logic [63:0] m_rf  [32];
    logic [63:0] m_mem [DEPTH];

    // Scoreboard.
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          debug_on = 1'b0;

    load_store_datapath #(.MEM_DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Ra           (Ra),
        .Rb           (Rb),
        .Rw           (Rw),
        .C            (C),
        .WE_RF        (WE_RF),
        .WE_MEM       (WE_MEM),
        .DEBUG_Dout   (DEBUG_Dout),
        .DEBUG_Ra_out (DEBUG_Ra_out)
    );

    // Clock: period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'(i);
    endfunction

    function automatic int model_index(input logic [4:0] rb, input logic [4:0] c);
        logic [63:0] a;
        a = m_rf[rb] + 64'(c);
        return int'(a % 64'(DEPTH));
    endfunction

    // Compare both views of the read data: internal nets and debug ports.
    task automatic observe(input string tag, input logic [63:0] exp_dout, input logic [63:0] exp_ra);
        exp_q.push_back(exp_dout);
        exp_q.push_back(exp_ra);
        check({tag, "_dout"}, dut.mem_rdata, exp_q.pop_front());
        check({tag, "_ra_out"}, dut.ra_data, exp_q.pop_front());
        check({tag, "_dbg_dout"}, DEBUG_Dout, debug_on ? exp_dout : 64'd0);
        check({tag, "_dbg_ra_out"}, DEBUG_Ra_out, debug_on ? exp_ra : 64'd0);
    endtask

    // One datapath cycle: drive, check pre-edge reads, then advance the model.
    task automatic do_op(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rw, input logic [4:0] c,
                         input logic we_rf, input logic we_mem);
        logic [63:0] old_rd, old_ra;
        int idx;
        @(negedge CLK);
        Ra = ra; Rb = rb; Rw = rw; C = c; WE_RF = we_rf; WE_MEM = we_mem;
        #1;
        idx    = model_index(rb, c);
        old_rd = m_mem[idx];
        old_ra = m_rf[ra];
        observe(tag, old_rd, old_ra);
        @(posedge CLK);
        if (we_rf && rw != 5'd0) m_rf[rw] = old_rd;
        if (we_mem) m_mem[idx] = old_ra;
    endtask

    // Read-only cycle checked against literal expectations.
    task automatic look(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] c, input logic [63:0] exp_dout, input logic [63:0] exp_ra);
        @(negedge CLK);
        Ra = ra; Rb = rb; Rw = 5'd0; C = c; WE_RF = 1'b0; WE_MEM = 1'b0;
        #1;
        observe(tag, exp_dout, exp_ra);
    endtask

    // Assert reset in the middle of a write cycle; outputs must follow at once
    // and the pending writes must be dropped.
    task automatic midcycle_reset(input string tag, input logic [4:0] ra, input logic [4:0] c);
        @(negedge CLK);
        Ra = ra; Rb = 5'd0; Rw = ra; C = c; WE_RF = 1'b1; WE_MEM = 1'b1;
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        observe({tag, "_now"}, 64'(c), 64'd0);
        @(posedge CLK);
        #1;
        observe({tag, "_held"}, 64'(c), 64'd0);
        @(negedge CLK);
        WE_RF = 1'b0; WE_MEM = 1'b0;
        #1;
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        Ra = '0; Rb = '0; Rw = '0; C = 5'd16; WE_RF = 1'b0; WE_MEM = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        debug_on = (DEBUG_Dout == 64'd16);
        check("reset_dout", dut.mem_rdata, 64'd16);
        check("reset_ra_out", dut.ra_data, 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // 1: ld x1,16(x0)
        do_op("t1_ld", 5'd0, 5'd0, 5'd1, 5'd16, 1'b1, 1'b0);
        look("t1_after", 5'd1, 5'd0, 5'd16, 64'd16, 64'd16);
        // 2: sd x1,20(x0)
        do_op("t2_sd", 5'd1, 5'd0, 5'd0, 5'd20, 1'b0, 1'b1);
        look("t2_after", 5'd1, 5'd0, 5'd20, 64'd16, 64'd16);
        // 3: load into x0 is ignored
        do_op("t3_ld_x0", 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        look("t3_after", 5'd0, 5'd0, 5'd5, 64'd5, 64'd0);
        // 4: address wrap, RF[2]=60 then 60+10 -> index 6
        do_op("t4_ld", 5'd0, 5'd0, 5'd2, 5'd28, 1'b1, 1'b0);
        look("t4_mid", 5'd2, 5'd0, 5'd28, 64'd28, 64'd28);
        do_op("t4_ld60", 5'd0, 5'd2, 5'd2, 5'd31, 1'b1, 1'b0);
        do_op("t4_ld60b", 5'd0, 5'd0, 5'd2, 5'd30, 1'b1, 1'b0);
        do_op("t4_ld60c", 5'd0, 5'd2, 5'd2, 5'd30, 1'b1, 1'b0);
        look("t4_rf2", 5'd2, 5'd0, 5'd0, 64'd0, 64'd60);
        look("t4_wrap", 5'd2, 5'd2, 5'd10, 64'd6, 64'd60);
        // 5: simultaneous load and store on x3 / MEM[7]
        do_op("t5_both", 5'd3, 5'd0, 5'd3, 5'd7, 1'b1, 1'b1);
        look("t5_after", 5'd3, 5'd0, 5'd7, 64'd0, 64'd7);
        // 6: redo 1-2 from clean state, then reset mid-cycle
        midcycle_reset("t6_pre", 5'd0, 5'd0);
        do_op("t6_ld", 5'd0, 5'd0, 5'd1, 5'd16, 1'b1, 1'b0);
        do_op("t6_sd", 5'd1, 5'd0, 5'd0, 5'd20, 1'b0, 1'b1);
        midcycle_reset("t6_rst", 5'd1, 5'd20);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            if (i % 150 == 149) begin
                midcycle_reset("rnd_rst", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end else begin
                do_op("rnd", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // Final sweep of the register file against the model.
        for (int r = 0; r < 32; r++) begin
            look("final_rf", 5'(r), 5'd0, 5'd0, m_mem[model_index(5'd0, 5'd0)], m_rf[r]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
